// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer between the control unit and a byte-wide data RAM
`timescale 1ns/1ps
module dmem_access_ctrl #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [15:0]       Mem_Data_Bus,
    output logic              dmem_read,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_VALID = 2'd2,
        WR       = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;
    logic [7:0]        rdata_q, rdata_n;
    logic [2:0]        cnt_q, cnt_n;

    // Only the low byte of the MDR is ever stored.
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rdata_n   = rdata_q;
        cnt_n     = cnt_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        dmem_read = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // A read wins when both requests arrive together; the write is dropped.
                if (rd_req) begin
                    addr_n  = addr;
                    cnt_n   = LAT_INIT;
                    state_n = RD_WAIT;
                end else if (wr_req) begin
                    addr_n  = addr;
                    wdata_n = wr_data[7:0];
                    state_n = WR;
                end
            end
            RD_WAIT: begin
                ram_re = 1'b1;
                cnt_n  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_n = ram_rdata;
                    state_n = RD_VALID;
                end
            end
            RD_VALID: begin
                dmem_read = 1'b1;
                done      = 1'b1;
                state_n   = IDLE;
            end
            WR: begin
                ram_we  = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign Mem_Data_Bus = {8'h00, rdata_q};
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl at RD_LAT 2, 1 and 7
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

    localparam int N = 3;
    localparam int LAT [N] = '{2, 1, 7};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_req    [N];
    logic        wr_req    [N];
    logic [15:0] addr      [N];
    logic [15:0] wr_data   [N];
    logic [15:0] ram_addr  [N];
    logic        ram_re    [N];
    logic        ram_we    [N];
    logic [7:0]  ram_wdata [N];
    logic [7:0]  ram_rdata [N];
    logic [15:0] mdb       [N];
    logic        dmem_read [N];
    logic        busy      [N];
    logic        done      [N];

    logic [7:0]  mem    [N][256];
    int          re_run [N];
    logic        pl_en;
    int          pl_k;
    logic [7:0]  pl_a, pl_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        dmem_access_ctrl #(.ADDR_W(16), .RD_LAT(LAT[k])) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .rd_req       (rd_req[k]),
            .wr_req       (wr_req[k]),
            .addr         (addr[k]),
            .wr_data      (wr_data[k]),
            .ram_addr     (ram_addr[k]),
            .ram_re       (ram_re[k]),
            .ram_we       (ram_we[k]),
            .ram_wdata    (ram_wdata[k]),
            .ram_rdata    (ram_rdata[k]),
            .Mem_Data_Bus (mdb[k]),
            .dmem_read    (dmem_read[k]),
            .busy         (busy[k]),
            .done         (done[k])
        );
    end

    // RAM model: read data is only valid in the cycle RD_LAT-1 after ram_re first rose.
    always @(posedge clk) begin
        if (pl_en) mem[pl_k][pl_a] <= pl_d;
        for (int k = 0; k < N; k++) begin
            if (ram_we[k]) mem[k][ram_addr[k][7:0]] <= ram_wdata[k];
            re_run[k] <= ram_re[k] ? re_run[k] + 1 : 0;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            ram_rdata[k] = (ram_re[k] && re_run[k] == LAT[k] - 1) ? mem[k][ram_addr[k][7:0]] : 8'hEE;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] outs(input int k);
        return {busy[k], ram_re[k], ram_we[k], done[k], dmem_read[k], ram_addr[k], ram_wdata[k], mdb[k]};
    endfunction

    task automatic preload(input int k, input logic [7:0] a, input logic [7:0] d);
        pl_k = k; pl_a = a; pl_d = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic request(input int k, input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        rd_req[k] = rd; wr_req[k] = wr; addr[k] = a; wr_data[k] = d;
        @(posedge clk); #1;
        rd_req[k] = 1'b0; wr_req[k] = 1'b0; addr[k] = 16'($urandom); wr_data[k] = 16'($urandom);
    endtask

    int          ob_re, ob_we, ob_done, ob_first;
    logic [15:0] ob_mdb1, ob_addr;
    logic [7:0]  ob_wd;
    logic        ob_dr1;

    task automatic observe(input int k, input int ncyc);
        ob_re = 0; ob_we = 0; ob_done = 0; ob_first = -1;
        ob_mdb1 = 16'hxxxx; ob_addr = 16'hxxxx; ob_wd = 8'hxx; ob_dr1 = 1'bx;
        for (int c = 1; c <= ncyc; c++) begin
            if (ram_re[k]) begin ob_re++; ob_addr = ram_addr[k]; end
            if (ram_we[k]) begin ob_we++; ob_addr = ram_addr[k]; ob_wd = ram_wdata[k]; end
            if (done[k]) begin
                ob_done++;
                if (ob_first < 0) begin ob_first = c; ob_mdb1 = mdb[k]; ob_dr1 = dmem_read[k]; end
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [7:0]  pre;
        int          lat;
        int          re_n;
        int          we_n;
        logic [15:0] mdb;
        logic        dr;
        logic [7:0]  mem_after;
    } vec_t;

    vec_t        vecs [5];
    vec_t        t;
    logic [7:0]  ref_mem [256];
    int          m_left, m_kind;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic        i_rd, i_wr;
    logic [15:0] i_a, i_d;
    int          first, second, ndone;
    logic [15:0] mdb1, mdb2, mdb_pre2;

    initial begin
        reset_n = 1'b0;
        pl_en = 1'b0; pl_k = 0; pl_a = '0; pl_d = '0;
        for (int k = 0; k < N; k++) begin
            rd_req[k] = 1'b0; wr_req[k] = 1'b0; addr[k] = '0; wr_data[k] = '0;
        end

        // Reset state
        #12;
        chk("reset_busy", busy[0], 1'b0);
        chk("reset_ram_re", ram_re[0], 1'b0);
        chk("reset_ram_we", ram_we[0], 1'b0);
        chk("reset_done_dmem_read", {done[0], dmem_read[0]}, 2'b00);
        chk("reset_ram_addr", ram_addr[0], 16'h0000);
        chk("reset_mdb", mdb[0], 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 8'hA5, 3, 2, 0, 16'h00A5, 1'b1, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 16'h0020, 16'h12C3, 8'h00, 1, 0, 1, 16'h00A5, 1'b0, 8'hC3};
        vecs[2] = '{1'b1, 1'b1, 16'h0030, 16'h1234, 8'h5C, 3, 2, 0, 16'h005C, 1'b1, 8'h5C};
        vecs[3] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 8'h7E, 3, 2, 0, 16'h007E, 1'b1, 8'h7E};
        vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hABFF, 8'h00, 1, 0, 1, 16'h007E, 1'b0, 8'hFF};

        for (int v = 0; v < 5; v++) begin
            t = vecs[v];
            preload(0, t.a[7:0], t.pre);
            request(0, t.rd, t.wr, t.a, t.d);
            observe(0, 12);
            chk($sformatf("v%0d_done_count", v), ob_done, 1);
            chk($sformatf("v%0d_latency", v), ob_first, t.lat);
            chk($sformatf("v%0d_re_cycles", v), ob_re, t.re_n);
            chk($sformatf("v%0d_we_cycles", v), ob_we, t.we_n);
            chk($sformatf("v%0d_ram_addr", v), ob_addr, t.a);
            chk($sformatf("v%0d_mdb_at_done", v), ob_mdb1, t.mdb);
            chk($sformatf("v%0d_dmem_read_at_done", v), ob_dr1, t.dr);
            chk($sformatf("v%0d_ram_byte", v), mem[0][t.a[7:0]], t.mem_after);
            chk($sformatf("v%0d_busy_after", v), busy[0], 1'b0);
            if (t.wr && !t.rd) chk($sformatf("v%0d_ram_wdata", v), ob_wd, t.d[7:0]);
        end

        // Store pulsed while a load is waiting on the RAM
        preload(0, 8'h40, 8'h96);
        request(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        request(0, 1'b0, 1'b1, 16'h0040, 16'h0011);
        observe(0, 10);
        chk("ign_done_count", ob_done, 1);
        chk("ign_we_cycles", ob_we, 0);
        chk("ign_mdb", ob_mdb1, 16'h0096);
        chk("ign_ram_byte", mem[0][8'h40], 8'h96);

        // Reset in the second RD_WAIT cycle
        preload(0, 8'h50, 8'h3C);
        request(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        @(posedge clk); #1;
        chk("abort_in_rd_wait", ram_re[0], 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_outputs_async", outs(0), 45'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        observe(0, 6);
        chk("abort_no_done", ob_done, 0);
        chk("abort_no_re", ob_re, 0);
        chk("abort_mdb", mdb[0], 16'h0000);
        chk("abort_busy", busy[0], 1'b0);
        request(0, 1'b1, 1'b0, 16'h0050, 16'h0000);
        observe(0, 8);
        chk("abort_reload_latency", ob_first, 3);
        chk("abort_reload_mdb", ob_mdb1, 16'h003C);

        // Back-to-back loads with rd_req held high, RD_LAT 1 and 7
        for (int k = 1; k < N; k++) begin
            preload(k, 8'h60, 8'h11);
            preload(k, 8'h61, 8'h22);
            rd_req[k] = 1'b1; addr[k] = 16'h0060;
            @(posedge clk); #1;
            addr[k] = 16'h0061;
            first = -1; second = -1; ndone = 0;
            mdb1 = 'x; mdb2 = 'x; mdb_pre2 = 'x;
            for (int c = 1; c <= 2 * LAT[k] + 8; c++) begin
                if (c == LAT[k] + 3) rd_req[k] = 1'b0;
                if (c == 2 * LAT[k] + 2) mdb_pre2 = mdb[k];
                if (done[k]) begin
                    ndone++;
                    if (first < 0) begin first = c; mdb1 = mdb[k]; end
                    else if (second < 0) begin second = c; mdb2 = mdb[k]; end
                end
                @(posedge clk); #1;
            end
            chk($sformatf("b2b_lat%0d_first_done", LAT[k]), first, LAT[k] + 1);
            chk($sformatf("b2b_lat%0d_second_done", LAT[k]), second, 2 * LAT[k] + 3);
            chk($sformatf("b2b_lat%0d_done_count", LAT[k]), ndone, 2);
            chk($sformatf("b2b_lat%0d_mdb_first", LAT[k]), mdb1, 16'h0011);
            chk($sformatf("b2b_lat%0d_mdb_held", LAT[k]), mdb_pre2, 16'h0011);
            chk($sformatf("b2b_lat%0d_mdb_second", LAT[k]), mdb2, 16'h0022);
        end

        // Randomized traffic on the RD_LAT=2 instance against a transaction-level model
        for (int a = 0; a < 256; a++) begin
            ref_mem[a] = 8'($urandom);
            preload(0, 8'(a), ref_mem[a]);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_left = 0; m_kind = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int i = 0; i < 600; i++) begin
            i_rd = ($urandom_range(0, 2) == 0);
            i_wr = ($urandom_range(0, 1) == 0);
            i_a  = 16'($urandom);
            i_d  = 16'($urandom);
            rd_req[0] = i_rd; wr_req[0] = i_wr; addr[0] = i_a; wr_data[0] = i_d;
            @(posedge clk);
            if (m_left == 0) begin
                if (i_rd) begin
                    m_kind = 1; m_left = LAT[0] + 1; m_addr = i_a;
                end else if (i_wr) begin
                    m_kind = 2; m_left = 1; m_addr = i_a; m_wdata = i_d[7:0];
                end
            end else begin
                if (m_kind == 2 && m_left == 1) ref_mem[m_addr[7:0]] = m_wdata;
                m_left--;
                if (m_kind == 1 && m_left == 1) m_rdata = ref_mem[m_addr[7:0]];
            end
            #1;
            chk($sformatf("rand_cycle%0d", i), outs(0),
                {m_left > 0, m_kind == 1 && m_left >= 2, m_kind == 2 && m_left == 1,
                 m_left == 1, m_kind == 1 && m_left == 1, m_addr, m_wdata, 8'h00, m_rdata});
        end
        rd_req[0] = 1'b0; wr_req[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        for (int a = 0; a < 256; a++) begin
            if (mem[0][a] !== ref_mem[a]) chk($sformatf("rand_ram_byte%0h", a), mem[0][a], ref_mem[a]);
        end
        chk("rand_final_idle", busy[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
